word_queue: RTL and testbench
=============================

// Module: word_queue
// PURPOSE
// - Circular FIFO of parallel words, directly downstream of the serial-to-parallel deserializer.
// - Accepts each completed word on enqueue_in and releases the oldest word on dequeue_in.
// - Reports occupancy, full and empty, so the deserializer stalls and the consumer polls.
// - Single clock domain; the deserializer output is already synchronous to clock_10KHz.
// PARAMETERS
// - WIDTH  8  data word width in bits
// - DEPTH  8  number of entries; power of two, >= 2
// PORTS
// - clock_10KHz  in   1                   queue clock; all state updates on posedge
// - rst          in   1                   reset: asynchronous, active-high
// - data_in      in   WIDTH               word from deserializer; sampled when enqueue_in=1
// - enqueue_in   in   1                   push request, one word per cycle high
// - dequeue_in   in   1                   pop request, one word per cycle high
// - data_out     out  WIDTH               last popped word (registered)
// - len_out      out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
// - full_out     out  1                   len_out == DEPTH
// - empty_out    out  1                   len_out == 0
// BEHAVIOUR
// - Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, len=0, data_out=0.
// - Reset outputs: full_out=0, empty_out=1. Storage array is not cleared.
// - Enqueue accepted iff enqueue_in && (!full || dequeue accepted same cycle).
// - Accepted enqueue: mem[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1 (mod DEPTH).
// - Dequeue accepted iff dequeue_in && !empty.
// - Accepted dequeue: data_out<=mem[rd_ptr] on that edge (1-cycle latency); rd_ptr<=rd_ptr+1 (mod DEPTH).
// - Rejected dequeue (empty): data_out holds its value; no pointer move.
// - Rejected enqueue (full, no dequeue): word dropped; state unchanged.
// - len: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
// - Simultaneous enq+deq while full: both accepted; len stays DEPTH.
// - Simultaneous enq+deq while empty: enqueue only, no bypass; data_out unchanged; len=1.
// - Pointer wrap: DEPTH-1 -> 0 with no bubble.
// - full_out and empty_out are decoded from registered len: valid the cycle after the causing edge.
// - Reset mid-operation: queue immediately empties; in-flight request on that edge ignored.
// CONFIGURATION
// - Macro WORD_QUEUE_OVERFLOW_EN.
// - Defined: adds port overflow_out (out, 1), a sticky flag.
//   - Set on the edge that drops an enqueue (full && enqueue_in && !dequeue_in).
//   - Cleared only by rst; reset value 0.
// - Undefined: port absent; dropped enqueues are silent. All other behaviour identical.
// STRUCTURE
// - Package queue_pkg:
//   - WIDTH_DEF, DEPTH_DEF
//   - typedef word_t = logic [WIDTH_DEF-1:0]
//   - typedef ptr_t = logic [$clog2(DEPTH_DEF)-1:0]
//   - typedef len_t = logic [$clog2(DEPTH_DEF):0]
// - Sub-module queue_mem: DEPTH x WIDTH register file; 1 sync write port, 1 async read port.
// - Parent word_queue holds pointers, len counter, accept logic and the data_out register.
// TESTING
// 1. Reset then idle: len_out=0, empty_out=1, full_out=0, data_out=0x00.
// 2. Enqueue 0x11..0x18 (8 cycles), then 8 dequeues: full_out=1 after 8th push; data_out 0x11..0x18 in order; then empty_out=1.
// 3. Full, enqueue 0x99 without dequeue: len_out stays 8; next 8 pops never show 0x99.
//    With WORD_QUEUE_OVERFLOW_EN: overflow_out=1 and sticky.
// 4. Full plus simultaneous enq 0xAA / deq: data_out=0x11, len_out=8; 0xAA emerges as 8th pop.
// 5. Empty plus simultaneous enq 0x5C / deq: data_out unchanged, len_out=1; next dequeue gives data_out=0x5C.
// 6. Push 5, pop 5, push 8, pop 8 (pointer wrap): FIFO order kept; then rst mid-stream with len=4: len_out=0, data_out=0x00 at once.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and defaults for the word queue.
// Optional overflow flag: define WORD_QUEUE_OVERFLOW_EN.
package queue_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  typedef logic [WIDTH_DEF-1:0]         word_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH_DEF):0]   len_t;

endpackage

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register file for the word queue.
// One synchronous write port, one asynchronous read port.
module queue_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/word_queue.sv
// Circular FIFO of deserialized words with occupancy flags.
// Define WORD_QUEUE_OVERFLOW_EN to add the sticky overflow_out port.
module word_queue
  import queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock_10KHz,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     enqueue_in,
  input  logic                     dequeue_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
`ifdef WORD_QUEUE_OVERFLOW_EN
  output logic                     overflow_out,
`endif
  output logic                     full_out,
  output logic                     empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_len;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_enq_ok;
  logic             w_deq_ok;

  assign w_full  = (r_len == LEN_FULL);
  assign w_empty = (r_len == '0);

  // A pop frees a slot on the same edge, so a full queue still takes a push.
  assign w_deq_ok = dequeue_in && !w_empty;
  assign w_enq_ok = enqueue_in && (!w_full || w_deq_ok);

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clock_10KHz),
    .i_we    (w_enq_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock_10KHz or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
      r_dout   <= '0;
    end else begin
      if (w_enq_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= w_rdata;
      end
      unique case ({w_enq_ok, w_deq_ok})
        2'b10:   r_len <= r_len + 1'b1;
        2'b01:   r_len <= r_len - 1'b1;
        default: r_len <= r_len;
      endcase
    end
  end

`ifdef WORD_QUEUE_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clock_10KHz or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (enqueue_in && w_full && !dequeue_in) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_out = r_overflow;
`endif

  assign data_out  = r_dout;
  assign len_out   = r_len;
  assign full_out  = w_full;
  assign empty_out = w_empty;

endmodule

// File: tb/tb_word_queue.sv
// Directed, table-driven bench for word_queue.
// Build with WORD_QUEUE_OVERFLOW_EN to also check overflow_out.
module tb_word_queue;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
`ifdef WORD_QUEUE_OVERFLOW_EN
  logic       overflow_out;
`endif

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic       enq;
    logic       deq;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] len;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vq[$];

  word_queue #(
    .WIDTH (8),
    .DEPTH (8)
  ) dut (
    .clock_10KHz (clk),
    .rst         (rst),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .dequeue_in  (dequeue_in),
    .data_out    (data_out),
    .len_out     (len_out),
`ifdef WORD_QUEUE_OVERFLOW_EN
    .overflow_out(overflow_out),
`endif
    .full_out    (full_out),
    .empty_out   (empty_out)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic d, input logic [7:0] di,
                     input logic [7:0] dout, input int len,
                     input logic f, input logic em);
    vec_t v;
    v.enq = e; v.deq = d; v.din = di; v.dout = dout;
    v.len = 4'(len); v.full = f; v.empty = em;
    vq.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic d, input logic [7:0] di);
    @(negedge clk);
    enqueue_in = e;
    dequeue_in = d;
    data_in    = di;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input logic [7:0] dout,
                           input int len, input logic f, input logic em);
    check({nm, ".dout"},  int'(data_out),  int'(dout));
    check({nm, ".len"},   int'(len_out),   len);
    check({nm, ".full"},  int'(full_out),  int'(f));
    check({nm, ".empty"}, int'(empty_out), int'(em));
  endtask

  initial begin
    rst = 1'b1;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    check_all("reset", 8'h00, 0, 1'b0, 1'b1);
`ifdef WORD_QUEUE_OVERFLOW_EN
    check("ovf_reset", int'(overflow_out), 0);
`endif

    // Fill 0x11..0x18, drain in order.
    for (int i = 0; i < 8; i++)
      add(1, 0, 8'(8'h11 + i), 8'h00, i + 1, i == 7, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'h00, 8'(8'h11 + i), 7 - i, 0, i == 7);
    // Refill 0x21..0x28, then a dropped 0x99.
    for (int i = 0; i < 8; i++)
      add(1, 0, 8'(8'h21 + i), 8'h18, i + 1, i == 7, 0);
    add(1, 0, 8'h99, 8'h18, 8, 1, 0);
    // Full with push+pop: 0x21 out, 0xAA in, length held.
    add(1, 1, 8'hAA, 8'h21, 8, 1, 0);
    for (int i = 0; i < 7; i++)
      add(0, 1, 8'h00, 8'(8'h22 + i), 7 - i, 0, 0);
    add(0, 1, 8'h00, 8'hAA, 0, 0, 1);
    // Empty with push+pop: no bypass.
    add(1, 1, 8'h5C, 8'hAA, 1, 0, 0);
    add(0, 1, 8'h00, 8'h5C, 0, 0, 1);
    add(0, 1, 8'h00, 8'h5C, 0, 0, 1);

    for (int k = 0; k < vq.size(); k++) begin
      cyc(vq[k].enq, vq[k].deq, vq[k].din);
      check_all($sformatf("vec%0d", k), vq[k].dout, int'(vq[k].len),
                vq[k].full, vq[k].empty);
`ifdef WORD_QUEUE_OVERFLOW_EN
      check($sformatf("ovf%0d", k), int'(overflow_out), int'(k >= 24));
`endif
    end

    // Pointer wrap: push 5, pop 5, push 8, pop 8.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("wrapA%0d", i), int'(data_out), 8'h30 + i);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    check("wrap_full", int'(full_out), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("wrapB%0d", i), int'(data_out), 8'h40 + i);
    end
    check("wrap_len", int'(len_out), 0);

    // Reset mid-stream with four words queued.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    check("pre_rst_len", int'(len_out), 4);
    @(negedge clk);
    enqueue_in = 1'b1;
    data_in = 8'hEE;
    rst = 1'b1;
    #1;
    check_all("rst_async", 8'h00, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_ignore_enq", int'(len_out), 0);
    @(negedge clk);
    rst = 1'b0;
    enqueue_in = 1'b0;
`ifdef WORD_QUEUE_OVERFLOW_EN
    check("ovf_cleared", int'(overflow_out), 0);
`endif
    cyc(1'b1, 1'b0, 8'h77);
    check("post_rst_len", int'(len_out), 1);
    cyc(1'b0, 1'b1, 8'h00);
    check_all("post_rst_pop", 8'h77, 0, 1'b0, 1'b1);

    cyc(1'b0, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
